// File: rtl/fd_stage_queue.sv
// Fetch/decode stage buffer: DEPTH-entry FIFO of {inst, seqNextPc} with valid/ready
// on both sides, synchronous flush, and the head entry presented as decode fields.
module fd_stage_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 12,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   inst,
  input  logic [PC_W-1:0]     seqNextPcIn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          shamt,
  output logic [4:0]          aluOp,
  output logic [INST_W-16:0]  imm,
  output logic [INST_W-6:0]   t,
  output logic [PC_W-1:0]     seqNextPcOut,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int M     = INST_W - 1;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] head;

  // in_ready looks only at occupancy, so a full buffer never accepts even while popping.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage is data only; stale entries are hidden by the out_valid gating below.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= inst;
      pc_mem[wr_ptr]   <= seqNextPcIn;
    end
  end

  assign head = inst_mem[rd_ptr];

  always_comb begin
    opcode       = '0;
    rd           = '0;
    rs           = '0;
    rt           = '0;
    shamt        = '0;
    aluOp        = '0;
    imm          = '0;
    t            = '0;
    seqNextPcOut = '0;
    if (out_valid) begin
      opcode       = head[M   -: 5];
      rd           = head[M-5 -: 5];
      rs           = head[M-10 -: 5];
      rt           = head[M-15 -: 5];
      shamt        = head[M-20 -: 5];
      aluOp        = head[M-25 -: 5];
      imm          = head[M-15:0];
      t            = head[M-5:0];
      seqNextPcOut = pc_mem[rd_ptr];
    end
  end

endmodule
